ysyx_22050078_mdu_ctrl: RTL

//  Multi-cycle M-extension sequencer beside the single-cycle EXU. Accepts any MUL*/DIV*/REM* op from the decoder.

---
 rtl/ysyx_22050078_mdu_ctrl_pkg.sv | 106 ++++++++++
 rtl/ysyx_22050078_mdu_step.sv | 49 ++++
 rtl/ysyx_22050078_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050078_mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_mdu_ctrl_pkg
//  Shared definitions for the multi-cycle M-extension unit:
//   - EXU op codes as seen at the EXU stage (M ops and a few base ops)
//   - MDU FSM state encoding, state/counter widths
//   - small op-classification helpers used by the sequencer
// ---------------------------------------------------------------------------
package ysyx_22050078_mdu_ctrl_pkg;

    localparam int EXU_OPT_WIDTH = 5;
    localparam int MDU_ST_WIDTH  = 3;
    localparam int MDU_CNT_WIDTH = 7;

    // Base integer ops (handled by the single-cycle EXU path)
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_ADD    = 5'd0;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SUB    = 5'd1;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_AND    = 5'd2;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_OR     = 5'd3;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_XOR    = 5'd4;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLL    = 5'd5;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRL    = 5'd6;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRA    = 5'd7;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLT    = 5'd8;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLTU   = 5'd9;

    // M-extension ops (handled by the MDU)
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_MUL    = 5'd16;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULH   = 5'd17;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULHSU = 5'd18;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULHU  = 5'd19;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULW   = 5'd20;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIV    = 5'd21;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVU   = 5'd22;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_REM    = 5'd23;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMU   = 5'd24;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVW   = 5'd25;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVUW  = 5'd26;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMW   = 5'd27;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMUW  = 5'd28;

    typedef enum logic [MDU_ST_WIDTH-1:0] {
        MDU_ST_IDLE = 3'd0,
        MDU_ST_PREP = 3'd1,
        MDU_ST_MRUN = 3'd2,
        MDU_ST_DRUN = 3'd3,
        MDU_ST_FIX  = 3'd4,
        MDU_ST_DONE = 3'd5
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_MUL, EXU_MULH, EXU_MULHSU, EXU_MULHU, EXU_MULW,
            EXU_DIV, EXU_DIVU, EXU_REM, EXU_REMU,
            EXU_DIVW, EXU_DIVUW, EXU_REMW, EXU_REMUW: is_mdu_op = 1'b1;
            default:                                  is_mdu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_w_op(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_MULW, EXU_DIVW, EXU_DIVUW, EXU_REMW, EXU_REMUW: is_w_op = 1'b1;
            default:                                            is_w_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_DIV, EXU_DIVU, EXU_REM, EXU_REMU,
            EXU_DIVW, EXU_DIVUW, EXU_REMW, EXU_REMUW: is_div_op = 1'b1;
            default:                                  is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_op(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_REM, EXU_REMU, EXU_REMW, EXU_REMUW: is_rem_op = 1'b1;
            default:                                is_rem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_mulh_op(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_MULH, EXU_MULHSU, EXU_MULHU: is_mulh_op = 1'b1;
            default:                         is_mulh_op = 1'b0;
        endcase
    endfunction

    // Signed interpretation of rs1
    function automatic logic src1_signed(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_MUL, EXU_MULH, EXU_MULHSU, EXU_MULW,
            EXU_DIV, EXU_REM, EXU_DIVW, EXU_REMW: src1_signed = 1'b1;
            default:                              src1_signed = 1'b0;
        endcase
    endfunction

    // Signed interpretation of rs2 (MULHSU treats rs2 as unsigned)
    function automatic logic src2_signed(input logic [EXU_OPT_WIDTH-1:0] op);
        case (op)
            EXU_MUL, EXU_MULH, EXU_MULW,
            EXU_DIV, EXU_REM, EXU_DIVW, EXU_REMW: src2_signed = 1'b1;
            default:                              src2_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050078_mdu_step.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_mdu_step
//  One combinational iteration of the MDU datapath on a {hi, lo} accumulator.
//   multiply : radix-2 shift-add; if acc[0] add operand into hi, then shift
//              the whole accumulator right by one (carry enters at the top).
//   divide   : restoring shift-subtract; shift {rem, quo} left by one, trial
//              subtract operand from rem, keep the difference and shift a 1
//              into the quotient if it did not go negative.
// Ports
//  acc      in   2*DATA_WIDTH  current accumulator {hi, lo}
//  operand  in   DATA_WIDTH    multiplicand or divisor (magnitude)
//  is_div   in   1             select divide step instead of multiply step
//  acc_next out  2*DATA_WIDTH  accumulator after this iteration
// ---------------------------------------------------------------------------
module ysyx_22050078_mdu_step #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    input  logic                    is_div,
    output logic [2*DATA_WIDTH-1:0] acc_next
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH;

    logic [DW:0] sum;
    logic [DW:0] rem_shift;
    logic [DW:0] diff;

    always_comb begin
        // Multiply: hi + (acc[0] ? operand : 0), one extra bit for the carry
        sum       = {1'b0, acc[AW-1:DW]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: remainder shifted left with the next dividend bit appended
        rem_shift = acc[AW-1:DW-1];
        diff      = rem_shift - {1'b0, operand};

        if (is_div) begin
            if (!diff[DW]) begin
                acc_next = {diff[DW-1:0], acc[DW-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[DW-1:0], acc[DW-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[DW-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_22050078_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_mdu_ctrl
//  Multi-cycle M-extension sequencer next to the single-cycle EXU. Accepts
//  MUL*/DIV*/REM* ops, stalls the front end while an iterative radix-2
//  datapath runs, and returns one result pulse to WBU.
//  Operands are converted to magnitudes in PREP, iterated in MRUN/DRUN,
//  and sign-corrected / selected in FIX. Divide-by-zero and signed overflow
//  bypass the iteration and go straight from PREP to DONE.
// Ports
//  clk        in   1              core clock
//  rst_n      in   1              asynchronous active-low reset
//  i_valid    in   1              decoded instruction valid (held while o_stall)
//  i_exu_opt  in   EXU_OPT_WIDTH  decoded EXU op code
//  i_src1     in   DATA_WIDTH     rs1 value
//  i_src2     in   DATA_WIDTH     rs2 value
//  i_flush    in   1              abort in-flight op
//  o_stall    out  1              freeze PC/IFU/IDU
//  o_valid    out  1              result valid, single-cycle pulse (DONE)
//  o_result   out  DATA_WIDTH     result, sign-extended for W ops
// Handshake: an op is taken in IDLE when i_valid & is_mdu & ~i_flush; the
//  source holds i_valid/op/operands while o_stall=1 and advances in the
//  o_valid cycle, where o_stall is already low.
// ---------------------------------------------------------------------------
module ysyx_22050078_mdu_ctrl
    import ysyx_22050078_mdu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = MDU_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [EXU_OPT_WIDTH-1:0] i_exu_opt,
    input  logic [DATA_WIDTH-1:0]    i_src1,
    input  logic [DATA_WIDTH-1:0]    i_src2,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_result
);

    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int AW = 2 * DATA_WIDTH;

    mdu_state_e state_q, state_d;

    logic [EXU_OPT_WIDTH-1:0] op_q;
    logic [DW-1:0]            a_q;
    logic [DW-1:0]            b_q;
    logic [DW-1:0]            m_q;       // multiplicand / divisor magnitude
    logic [AW-1:0]            acc_q;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic                     q_neg_q;   // product or quotient sign
    logic                     r_neg_q;   // remainder sign
    logic [DW-1:0]            result_q;

    logic                     accept;
    logic [AW-1:0]            step_acc;

    // PREP datapath
    logic                     w_op;
    logic [DW-1:0]            a_ext, b_ext, a_abs, b_abs, min_ext;
    logic                     a_neg, b_neg;
    logic                     div_zero, div_ovf, prep_special;
    logic [DW-1:0]            special_result;
    logic [AW-1:0]            prep_acc;
    logic [DW-1:0]            prep_m;
    logic [CNT_WIDTH-1:0]     prep_cnt;

    // FIX datapath
    logic [AW-1:0]            mul_full;
    logic [DW-1:0]            quo_raw, rem_raw, quo, rem, div_sel, fix_result;

    assign accept = i_valid & is_mdu_op(i_exu_opt) & ~i_flush;

    assign o_valid  = (state_q == MDU_ST_DONE);
    assign o_result = result_q;
    assign o_stall  = ((state_q != MDU_ST_IDLE) && (state_q != MDU_ST_DONE)) ||
                      ((state_q == MDU_ST_IDLE) && i_valid && is_mdu_op(i_exu_opt));

    ysyx_22050078_mdu_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .acc      (acc_q),
        .operand  (m_q),
        .is_div   (is_div_op(op_q)),
        .acc_next (step_acc)
    );

    // Operand conditioning, special-case detection and accumulator seeding
    always_comb begin
        w_op = is_w_op(op_q);

        if (w_op) begin
            a_ext = src1_signed(op_q) ? {{HW{a_q[HW-1]}}, a_q[HW-1:0]} : {{HW{1'b0}}, a_q[HW-1:0]};
            b_ext = src2_signed(op_q) ? {{HW{b_q[HW-1]}}, b_q[HW-1:0]} : {{HW{1'b0}}, b_q[HW-1:0]};
            min_ext = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
        end else begin
            a_ext   = a_q;
            b_ext   = b_q;
            min_ext = {1'b1, {(DW-1){1'b0}}};
        end

        a_neg = src1_signed(op_q) & a_ext[DW-1];
        b_neg = src2_signed(op_q) & b_ext[DW-1];
        // Magnitude of MIN is MIN read as unsigned, which the iteration handles
        a_abs = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_abs = b_neg ? (~b_ext + 1'b1) : b_ext;

        div_zero     = is_div_op(op_q) && (b_ext == '0);
        div_ovf      = is_div_op(op_q) && src1_signed(op_q) &&
                       (a_ext == min_ext) && (b_ext == '1);
        prep_special = div_zero || div_ovf;

        if (div_zero) begin
            if (is_rem_op(op_q)) begin
                special_result = w_op ? {{HW{a_q[HW-1]}}, a_q[HW-1:0]} : a_q;
            end else begin
                special_result = '1;
            end
        end else begin
            // Overflow: a_ext already holds the (sign-extended) MIN
            special_result = is_rem_op(op_q) ? '0 : a_ext;
        end

        if (is_div_op(op_q)) begin
            // W dividends sit in the upper half so 32 steps consume them
            prep_acc = w_op ? {{DW{1'b0}}, a_abs[HW-1:0], {HW{1'b0}}} : {{DW{1'b0}}, a_abs};
            prep_m   = b_abs;
        end else begin
            prep_acc = {{DW{1'b0}}, b_abs};
            prep_m   = a_abs;
        end

        prep_cnt = w_op ? CNT_WIDTH'(HW) : CNT_WIDTH'(DW);
    end

    // Sign correction and result selection
    always_comb begin
        mul_full = q_neg_q ? (~acc_q + 1'b1) : acc_q;

        quo_raw = is_w_op(op_q) ? {{HW{1'b0}}, acc_q[HW-1:0]} : acc_q[DW-1:0];
        rem_raw = acc_q[AW-1:DW];
        quo     = q_neg_q ? (~quo_raw + 1'b1) : quo_raw;
        rem     = r_neg_q ? (~rem_raw + 1'b1) : rem_raw;
        div_sel = is_rem_op(op_q) ? rem : quo;

        if (is_div_op(op_q)) begin
            fix_result = is_w_op(op_q) ? {{HW{div_sel[HW-1]}}, div_sel[HW-1:0]} : div_sel;
        end else if (is_mulh_op(op_q)) begin
            fix_result = mul_full[AW-1:DW];
        end else if (is_w_op(op_q)) begin
            // After 32 steps the W product sits at acc[AW-1:HW]
            fix_result = {{HW{mul_full[DW-1]}}, mul_full[DW-1:HW]};
        end else begin
            fix_result = mul_full[DW-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_ST_IDLE: if (accept) state_d = MDU_ST_PREP;
            MDU_ST_PREP: begin
                if (prep_special)          state_d = MDU_ST_DONE;
                else if (is_div_op(op_q))  state_d = MDU_ST_DRUN;
                else                       state_d = MDU_ST_MRUN;
            end
            MDU_ST_MRUN,
            MDU_ST_DRUN: if (cnt_q == CNT_WIDTH'(1)) state_d = MDU_ST_FIX;
            MDU_ST_FIX:  state_d = MDU_ST_DONE;
            MDU_ST_DONE: state_d = MDU_ST_IDLE;
            default:     state_d = MDU_ST_IDLE;
        endcase
        if (i_flush && (state_q != MDU_ST_IDLE)) state_d = MDU_ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MDU_ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else if (i_flush && (state_q != MDU_ST_IDLE)) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                MDU_ST_IDLE: begin
                    if (accept) begin
                        op_q <= i_exu_opt;
                        a_q  <= i_src1;
                        b_q  <= i_src2;
                    end
                end
                MDU_ST_PREP: begin
                    m_q     <= prep_m;
                    acc_q   <= prep_acc;
                    cnt_q   <= prep_special ? '0 : prep_cnt;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    if (prep_special) result_q <= special_result;
                end
                MDU_ST_MRUN,
                MDU_ST_DRUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q - 1'b1;
                end
                MDU_ST_FIX: result_q <= fix_result;
                default: ;
            endcase
        end
    end

endmodule
